// File: rtl/ball_phys_pkg.sv
// Shared types and helpers for the ball contact engine.
// The optional kick-charge feature is controlled by the KICK_CHARGE_EN macro.
package ball_phys_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONTACT  = 2'd1,
    COOLDOWN = 2'd2
  } contact_state_t;

  typedef enum logic [1:0] {
    LEFT   = 2'd0,
    RIGHT  = 2'd1,
    TOP    = 2'd2,
    BOTTOM = 2'd3
  } hit_dir_t;

  localparam int KICK_VX_DEFAULT    = 10;
  localparam int KICK_VY_DEFAULT    = -14;
  localparam int CHARGE_MAX_DEFAULT = 6;
  localparam int COOLDOWN_DEFAULT   = 4;

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                    input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/player_contact_unit.sv
// One player channel: box-vs-ball overlap, contact FSM with re-hit cooldown,
// kick edge detection, optional kick charge (KICK_CHARGE_EN) and the impulse
// this player contributes in the current frame.
module player_contact_unit import ball_phys_pkg::*; #(
  parameter int W               = 10,
  parameter int COOLDOWN_FRAMES = COOLDOWN_DEFAULT,
  parameter int KICK_VX         = KICK_VX_DEFAULT,
  parameter int KICK_VY         = KICK_VY_DEFAULT
`ifdef KICK_CHARGE_EN
  , parameter int CHARGE_MAX    = CHARGE_MAX_DEFAULT
`endif
) (
  input  logic                frame_clk,
  input  logic                reset_n,
  input  logic [W-1:0]        p_x,
  input  logic [W-1:0]        p_y,
  input  logic [W-1:0]        p_w,
  input  logic [W-1:0]        p_h,
  input  logic [W-1:0]        p_vel_x,
  input  logic [W-1:0]        p_vel_y,
  input  logic                p_kicking,
  input  logic                p_facing_left,
  input  logic [W-1:0]        ball_x,
  input  logic [W-1:0]        ball_y,
  input  logic [W-1:0]        ball_r,
  input  logic [W-1:0]        ball_vel_x,
  input  logic [W-1:0]        ball_vel_y,
  output logic                fire,
  output logic signed [W+2:0] imp_x,
  output logic signed [W+2:0] imp_y,
  output contact_state_t      state_dbg
);

  localparam int TW = W + 3;
  // Right/bottom bounds add three W-bit terms, so two guard bits keep them exact.
  localparam int XW = W + 2;
  localparam int CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;

  contact_state_t    state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              kick_fired, kick_fired_nxt;
  logic              kick_prev;
  logic              kick_start;
  logic              overlap;
  hit_dir_t          hit_dir;
  logic [XW-1:0]     cx, cy;
  logic signed [TW-1:0] pvx, pvy, bvx, bvy;
  logic signed [TW-1:0] kick_mag, kick_vy_t;
  logic signed [TW-1:0] push_fx, push_fy, kick_fx, kick_fy;

  assign pvx = {{3{p_vel_x[W-1]}}, p_vel_x};
  assign pvy = {{3{p_vel_y[W-1]}}, p_vel_y};
  assign bvx = {{3{ball_vel_x[W-1]}}, ball_vel_x};
  assign bvy = {{3{ball_vel_y[W-1]}}, ball_vel_y};

  assign overlap = (XW'(ball_x) + XW'(ball_r) > XW'(p_x)) &&
                   (XW'(ball_x) < XW'(p_x) + XW'(p_w) + XW'(ball_r)) &&
                   (XW'(ball_y) + XW'(ball_r) > XW'(p_y)) &&
                   (XW'(ball_y) < XW'(p_y) + XW'(p_h) + XW'(ball_r));

  assign kick_start = p_kicking & ~kick_prev;
  assign cx = XW'(p_x) + XW'(p_w >> 1);
  assign cy = XW'(p_y) + XW'(p_h >> 1);

`ifdef KICK_CHARGE_EN
  localparam int CHW = $clog2(CHARGE_MAX + 2);
  logic [CHW-1:0]       charge;
  logic signed [TW-1:0] charge_ext;

  assign charge_ext = signed'({{(TW - CHW){1'b0}}, charge});
  assign kick_mag   = TW'(KICK_VX) + charge_ext;
  assign kick_vy_t  = TW'(KICK_VY) - (charge_ext >>> 1);

  // Charge builds while the button is held away from contact; a kick spends it.
  always_ff @(posedge frame_clk or negedge reset_n) begin
    if (!reset_n) begin
      charge <= '0;
    end else if (!p_kicking || fire) begin
      charge <= '0;
    end else if (state != CONTACT && charge < CHW'(CHARGE_MAX)) begin
      charge <= charge + 1'b1;
    end
  end
`else
  assign kick_mag  = TW'(KICK_VX);
  assign kick_vy_t = TW'(KICK_VY);
`endif

  // Classify which face of the box the ball struck, in priority order.
  always_comb begin
    hit_dir = BOTTOM;
    if (XW'(ball_x) < cx && bvx > 0)        hit_dir = LEFT;
    else if (XW'(ball_x) >= cx && bvx < 0)  hit_dir = RIGHT;
    else if (XW'(ball_y) < cy)              hit_dir = TOP;
    else                                    hit_dir = BOTTOM;
  end

  // Candidate impulses for a plain push and for a kick.
  always_comb begin
    push_fx = pvx <<< 1;
    push_fy = TW'(-6);
    case (hit_dir)
      LEFT, RIGHT: begin
        push_fx = (pvx <<< 1) - (bvx <<< 1);
        push_fy = (pvy < 0) ? (pvy - TW'(5)) : TW'(-6);
      end
      default: begin
        push_fx = pvx <<< 1;
        push_fy = pvy - (bvy <<< 1);
      end
    endcase
    kick_fx = (p_facing_left ? -kick_mag : kick_mag) - bvx + pvx;
    kick_fy = kick_vy_t - bvy;
  end

  // Contact FSM: next state, cooldown count, kick latch and fire strobe.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    kick_fired_nxt = kick_fired;
    fire           = 1'b0;
    case (state)
      IDLE: begin
        if (overlap) begin
          state_nxt      = CONTACT;
          fire           = 1'b1;
          kick_fired_nxt = p_kicking;
        end
      end
      CONTACT: begin
        if (kick_start && !kick_fired) begin
          fire           = 1'b1;
          kick_fired_nxt = 1'b1;
        end
        if (!overlap) begin
          state_nxt      = COOLDOWN;
          cnt_nxt        = CW'(COOLDOWN_FRAMES - 1);
          kick_fired_nxt = 1'b0;
        end
      end
      COOLDOWN: begin
        if (overlap) begin
          state_nxt = CONTACT;
          if (kick_start) begin
            fire           = 1'b1;
            kick_fired_nxt = 1'b1;
          end
        end else if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Player impulse: a kick whenever the button is down at fire time.
  always_comb begin
    imp_x = '0;
    imp_y = '0;
    if (fire) begin
      imp_x = p_kicking ? kick_fx : push_fx;
      imp_y = p_kicking ? kick_fy : push_fy;
    end
  end

  // FSM state, cooldown counter, kick latch and previous kick level.
  always_ff @(posedge frame_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      kick_fired <= 1'b0;
      kick_prev  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      kick_fired <= kick_fired_nxt;
      kick_prev  <= p_kicking;
    end
  end

  assign state_dbg = state;

endmodule

// File: rtl/ball_contact_engine.sv
// N-player ball contact engine: per-player contact units, impulse sum,
// saturation and a registered one-frame force strobe.
// Optional kick charge is enabled by defining KICK_CHARGE_EN.
//
// Handshake: there is no back-pressure. force_valid is a one-frame strobe;
// force_x/force_y/force_src are meaningful only while force_valid is high
// and are zero otherwise. Inputs sampled at frame edge k appear after edge k.
module ball_contact_engine import ball_phys_pkg::*; #(
  parameter int N_PLAYERS       = 2,
  parameter int W               = 10,
  parameter int COOLDOWN_FRAMES = COOLDOWN_DEFAULT,
  parameter int KICK_VX         = KICK_VX_DEFAULT,
  parameter int KICK_VY         = KICK_VY_DEFAULT
`ifdef KICK_CHARGE_EN
  , parameter int CHARGE_MAX    = CHARGE_MAX_DEFAULT
`endif
) (
  input  logic                            frame_clk,
  input  logic                            reset_n,
  input  logic [N_PLAYERS-1:0][W-1:0]     p_x,
  input  logic [N_PLAYERS-1:0][W-1:0]     p_y,
  input  logic [N_PLAYERS-1:0][W-1:0]     p_w,
  input  logic [N_PLAYERS-1:0][W-1:0]     p_h,
  input  logic [N_PLAYERS-1:0][W-1:0]     p_vel_x,
  input  logic [N_PLAYERS-1:0][W-1:0]     p_vel_y,
  input  logic [N_PLAYERS-1:0]            p_kicking,
  input  logic [N_PLAYERS-1:0]            p_facing_left,
  input  logic [W-1:0]                    ball_x,
  input  logic [W-1:0]                    ball_y,
  input  logic [W-1:0]                    ball_r,
  input  logic [W-1:0]                    ball_vel_x,
  input  logic [W-1:0]                    ball_vel_y,
  output logic                            force_valid,
  output logic signed [W-1:0]             force_x,
  output logic signed [W-1:0]             force_y,
  output logic [N_PLAYERS-1:0]            force_src,
  output logic [N_PLAYERS-1:0][1:0]       dbg_state
);

  localparam int TW = W + 3;
  localparam int SW = TW + $clog2(N_PLAYERS);

  logic [N_PLAYERS-1:0]  fire;
  logic signed [TW-1:0]  imp_x [N_PLAYERS];
  logic signed [TW-1:0]  imp_y [N_PLAYERS];
  logic signed [SW-1:0]  sum_x, sum_y;
  logic signed [31:0]    sat_x, sat_y;

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_player
    contact_state_t st;

    player_contact_unit #(
      .W               (W),
      .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
      .KICK_VX         (KICK_VX),
      .KICK_VY         (KICK_VY)
`ifdef KICK_CHARGE_EN
      , .CHARGE_MAX    (CHARGE_MAX)
`endif
    ) u_pcu (
      .frame_clk     (frame_clk),
      .reset_n       (reset_n),
      .p_x           (p_x[i]),
      .p_y           (p_y[i]),
      .p_w           (p_w[i]),
      .p_h           (p_h[i]),
      .p_vel_x       (p_vel_x[i]),
      .p_vel_y       (p_vel_y[i]),
      .p_kicking     (p_kicking[i]),
      .p_facing_left (p_facing_left[i]),
      .ball_x        (ball_x),
      .ball_y        (ball_y),
      .ball_r        (ball_r),
      .ball_vel_x    (ball_vel_x),
      .ball_vel_y    (ball_vel_y),
      .fire          (fire[i]),
      .imp_x         (imp_x[i]),
      .imp_y         (imp_y[i]),
      .state_dbg     (st)
    );

    assign dbg_state[i] = st;
  end

  // Sum the impulses of every player firing this frame, then saturate.
  always_comb begin
    sum_x = '0;
    sum_y = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (fire[i]) begin
        sum_x = sum_x + SW'(imp_x[i]);
        sum_y = sum_y + SW'(imp_y[i]);
      end
    end
    sat_x = sat_signed(32'(sum_x), W);
    sat_y = sat_signed(32'(sum_y), W);
  end

  // Output register: one strobe per frame, zeros when nobody fired.
  always_ff @(posedge frame_clk or negedge reset_n) begin
    if (!reset_n) begin
      force_valid <= 1'b0;
      force_x     <= '0;
      force_y     <= '0;
      force_src   <= '0;
    end else begin
      force_valid <= |fire;
      force_src   <= fire;
      force_x     <= (|fire) ? W'(sat_x) : '0;
      force_y     <= (|fire) ? W'(sat_y) : '0;
    end
  end

endmodule

// File: tb/tb_ball_contact_engine.sv
// Self-checking bench for ball_contact_engine (N_PLAYERS=2, W=10).
// Define KICK_CHARGE_EN for both bench and RTL to cover the charge feature.
module tb_ball_contact_engine;

  localparam int N  = 2;
  localparam int W  = 10;
  localparam int CD = 4;
  localparam int FAR = 1000;

  typedef struct packed {
    logic         v;
    logic [W-1:0] fx;
    logic [W-1:0] fy;
    logic [N-1:0] src;
  } exp_t;

  logic                 frame_clk = 1'b0;
  logic                 reset_n;
  logic [N-1:0][W-1:0]  p_x, p_y, p_w, p_h, p_vel_x, p_vel_y;
  logic [N-1:0]         p_kicking, p_facing_left;
  logic [W-1:0]         ball_x, ball_y, ball_r, ball_vel_x, ball_vel_y;
  logic                 force_valid;
  logic signed [W-1:0]  force_x, force_y;
  logic [N-1:0]         force_src;
  logic [N-1:0][1:0]    dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t exp_q[$];

  // Reference model state: touching flag, frames spent away since last contact.
  bit m_touch  [N];
  int m_absent [N];
  bit m_kicked [N];
  bit m_prev   [N];
  int m_charge [N];

  ball_contact_engine #(.N_PLAYERS(N), .W(W)) dut (
    .frame_clk     (frame_clk),
    .reset_n       (reset_n),
    .p_x           (p_x),
    .p_y           (p_y),
    .p_w           (p_w),
    .p_h           (p_h),
    .p_vel_x       (p_vel_x),
    .p_vel_y       (p_vel_y),
    .p_kicking     (p_kicking),
    .p_facing_left (p_facing_left),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .ball_r        (ball_r),
    .ball_vel_x    (ball_vel_x),
    .ball_vel_y    (ball_vel_y),
    .force_valid   (force_valid),
    .force_x       (force_x),
    .force_y       (force_y),
    .force_src     (force_src),
    .dbg_state     (dbg_state)
  );

  // Clock and watchdog
  always #5 frame_clk = ~frame_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_touch[i] = 0; m_absent[i] = FAR; m_kicked[i] = 0;
      m_prev[i] = 0;  m_charge[i] = 0;
    end
    exp_q.delete();
  endtask

  // One frame of the reference model, evaluated on the current inputs.
  task automatic model_step(output exp_t e);
    int sum_x, sum_y;
    logic [N-1:0] src;
    sum_x = 0; sum_y = 0; src = '0;
    for (int i = 0; i < N; i++) begin
      int px, py, pw, ph, bx, by, br, pvx, pvy, bvx, bvy, ch, mag, fx, fy, cx, cy;
      bit ov, ks, fires, was_touch;
      px = int'(p_x[i]); py = int'(p_y[i]); pw = int'(p_w[i]); ph = int'(p_h[i]);
      bx = int'(ball_x); by = int'(ball_y); br = int'(ball_r);
      pvx = sx(p_vel_x[i]); pvy = sx(p_vel_y[i]);
      bvx = sx(ball_vel_x); bvy = sx(ball_vel_y);
      ov = (bx + br > px) && (bx < px + pw + br) && (by + br > py) && (by < py + ph + br);
      ks = p_kicking[i] && !m_prev[i];
      ch = m_charge[i];
      was_touch = m_touch[i];
      fires = 0;
      if (ov) begin
        if (m_touch[i]) begin
          if (ks && !m_kicked[i]) begin fires = 1; m_kicked[i] = 1; end
        end else if (m_absent[i] <= CD) begin
          if (ks) begin fires = 1; m_kicked[i] = 1; end
        end else begin
          fires = 1; m_kicked[i] = p_kicking[i];
        end
        m_touch[i] = 1; m_absent[i] = 0;
      end else if (m_touch[i]) begin
        if (ks && !m_kicked[i]) fires = 1;
        m_kicked[i] = 0; m_touch[i] = 0; m_absent[i] = 1;
      end else if (m_absent[i] < FAR) begin
        m_absent[i]++;
      end
`ifdef KICK_CHARGE_EN
      if (!p_kicking[i] || fires) m_charge[i] = 0;
      else if (!was_touch && ch < 6) m_charge[i] = ch + 1;
`else
      ch = 0;
`endif
      m_prev[i] = p_kicking[i];
      if (fires) begin
        if (p_kicking[i]) begin
          mag = 10 + ch;
          fx = (p_facing_left[i] ? -mag : mag) - bvx + pvx;
          fy = -14 - ch / 2 - bvy;
        end else begin
          cx = px + pw / 2; cy = py + ph / 2;
          if ((bx < cx && bvx > 0) || (bx >= cx && bvx < 0)) begin
            fx = 2 * pvx - 2 * bvx;
            fy = (pvy < 0) ? pvy - 5 : -6;
          end else begin
            fx = 2 * pvx;
            fy = pvy - 2 * bvy;
          end
        end
        sum_x += fx; sum_y += fy; src[i] = 1'b1;
      end
    end
    if (sum_x > 511) sum_x = 511; else if (sum_x < -512) sum_x = -512;
    if (sum_y > 511) sum_y = 511; else if (sum_y < -512) sum_y = -512;
    e.v   = |src;
    e.fx  = W'(sum_x);
    e.fy  = W'(sum_y);
    e.src = src;
  endtask

  // Scoreboard: compare the registered outputs against the oldest expectation.
  task automatic sb_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_valid"}, force_valid, e.v);
    check({tag, "_fx"}, $signed(force_x), $signed(e.fx));
    check({tag, "_fy"}, $signed(force_y), $signed(e.fy));
    check({tag, "_src"}, force_src, e.src);
  endtask

  // Driver tasks
  task automatic run_frame(input string tag);
    exp_t e;
    model_step(e);
    exp_q.push_back(e);
    @(posedge frame_clk);
    #1;
    sb_check(tag);
  endtask

  task automatic set_player(input int i, input int px, input int py, input int pw,
                            input int ph, input int vx, input int vy);
    p_x[i] = W'(px); p_y[i] = W'(py); p_w[i] = W'(pw); p_h[i] = W'(ph);
    p_vel_x[i] = W'(vx); p_vel_y[i] = W'(vy);
  endtask

  task automatic set_ball(input int bx, input int by, input int br,
                          input int vx, input int vy);
    ball_x = W'(bx); ball_y = W'(by); ball_r = W'(br);
    ball_vel_x = W'(vx); ball_vel_y = W'(vy);
  endtask

  task automatic park();
    set_player(0, 100, 300, 32, 48, 0, 0);
    set_player(1, 600, 100, 32, 48, 0, 0);
    set_ball(10, 10, 4, 0, 0);
    p_kicking = '0; p_facing_left = '0;
  endtask

  task automatic release_reset();
    @(posedge frame_clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  function automatic int clamp_coord(input int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  function automatic int rnd_vel();
    if ($urandom_range(0, 3) == 0) return sx(W'($urandom_range(0, 1023)));
    return $urandom_range(0, 40) - 20;
  endfunction

  initial begin
    int tgt;
    reset_n = 1'b1;
    park();
    #1 reset_n = 1'b0;
    #2;
    check("rst_valid", force_valid, 0);
    check("rst_fx", $signed(force_x), 0);
    check("rst_fy", $signed(force_y), 0);
    check("rst_src", force_src, 0);
    check("rst_state", dbg_state, 0);
    release_reset();
    run_frame("idle");

    // Push from the left face
    set_ball(95, 320, 8, 4, 0);
    run_frame("push");
    check("push_k_valid", force_valid, 1);
    check("push_k_fx", $signed(force_x), -8);
    check("push_k_fy", $signed(force_y), -6);
    check("push_k_src", force_src, 1);
    run_frame("push_hold");
    check("push_hold_k_valid", force_valid, 0);

    // Kick edge by P1 facing left
    set_player(1, 300, 300, 32, 48, 0, 0);
    p_facing_left[1] = 1'b1;
    set_ball(310, 320, 8, 0, 0);
    run_frame("p1_enter");
    p_kicking[1] = 1'b1;
    run_frame("kick");
    check("kick_k_fx", $signed(force_x), -10);
    check("kick_k_fy", $signed(force_y), -14);
    check("kick_k_src", force_src, 2);
    run_frame("kick_hold");
    check("kick_hold_k_valid", force_valid, 0);

    // Both players push in the same frame; sum saturates
    #2 reset_n = 1'b0;
    park();
    release_reset();
    set_player(0, 100, 300, 32, 48, 200, 0);
    set_player(1, 100, 300, 32, 48, 200, 0);
    set_ball(110, 310, 8, 0, 0);
    run_frame("both");
    check("both_k_fx", $signed(force_x), 511);
    check("both_k_src", force_src, 3);

    // Reset mid-frame clears outputs with no clock edge
    #2 reset_n = 1'b0;
    #1;
    check("midrst_valid", force_valid, 0);
    check("midrst_fx", $signed(force_x), 0);
    check("midrst_fy", $signed(force_y), 0);
    check("midrst_src", force_src, 0);
    park();
    release_reset();

    // Cooldown: short absence is silent, long absence re-hits
    set_ball(95, 320, 8, 4, 0);
    run_frame("cd_first");
    run_frame("cd_hold");
    set_ball(10, 10, 4, 0, 0);
    repeat (2) run_frame("cd_out2");
    set_ball(95, 320, 8, 4, 0);
    run_frame("cd_back2");
    check("cd_back2_k_valid", force_valid, 0);
    set_ball(10, 10, 4, 0, 0);
    repeat (5) run_frame("cd_out5");
    set_ball(95, 320, 8, 4, 0);
    run_frame("cd_back5");
    check("cd_back5_k_valid", force_valid, 1);

    // Held kick out of contact, then contact facing right
    #2 reset_n = 1'b0;
    park();
    release_reset();
    p_kicking[0] = 1'b1;
    repeat (8) run_frame("charge");
    set_ball(110, 310, 8, 0, 0);
    run_frame("charged_kick");
`ifdef KICK_CHARGE_EN
    check("charged_k_fx", $signed(force_x), 16);
    check("charged_k_fy", $signed(force_y), -17);
`else
    check("charged_k_fx", $signed(force_x), 10);
    check("charged_k_fy", $signed(force_y), -14);
`endif
    p_kicking = '0;
    run_frame("charge_end");

    // Randomized frames near the players
    #2 reset_n = 1'b0;
    park();
    release_reset();
    tgt = 0;
    for (int f = 0; f < 400; f++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 15) == 0)
          set_player(i, $urandom_range(40, 900), $urandom_range(40, 900),
                     $urandom_range(8, 64), $urandom_range(8, 64), 0, 0);
        p_vel_x[i] = W'(rnd_vel());
        p_vel_y[i] = W'(rnd_vel());
        if ($urandom_range(0, 3) == 0) p_kicking[i] = ~p_kicking[i];
        if ($urandom_range(0, 7) == 0) p_facing_left[i] = ~p_facing_left[i];
      end
      if ($urandom_range(0, 2) == 0) begin
        tgt = $urandom_range(0, N - 1);
        ball_r = W'($urandom_range(2, 16));
        if ($urandom_range(0, 3) == 0) begin
          ball_x = W'($urandom_range(0, 1023));
          ball_y = W'($urandom_range(0, 1023));
        end else begin
          ball_x = W'(clamp_coord(int'(p_x[tgt]) + $urandom_range(0, int'(p_w[tgt]) + 40) - 20));
          ball_y = W'(clamp_coord(int'(p_y[tgt]) + $urandom_range(0, int'(p_h[tgt]) + 40) - 20));
        end
      end
      ball_vel_x = W'(rnd_vel());
      ball_vel_y = W'(rnd_vel());
      run_frame("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
